// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment digit scanner.
//   phase_e   : slot phase (BLANK = all enables off, ON = one digit lit)
//   NIBBLE_W  : width of one BCD/hex digit
//   en_on/en_off : digit-enable drive levels for a given board polarity
package seg_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } phase_e;

    // Level that lights a digit common line (common-anode boards are active-low).
    function automatic logic en_on(input bit active_low);
        return active_low ? 1'b0 : 1'b1;
    endfunction

    function automatic logic en_off(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/seg_lzb_mask.sv
// Leading-zero suppression mask, purely combinational.
//   digits_i : NUM_DIGITS nibbles, digit 0 in [3:0] (rightmost)
//   lzb_i    : 1 enables leading-zero blanking
//   mask_o   : bit k set when digit k must be blanked; bit 0 is never set
module seg_lzb_mask
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] digits_i,
    input  logic                           lzb_i,
    output logic [NUM_DIGITS-1:0]          mask_o
);

    // Walk from the most significant digit down; a digit is suppressed only
    // while every nibble from it upwards has been zero.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        mask_o   = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run  = zero_run & (digits_i[k*NIBBLE_W +: NIBBLE_W] == '0);
            mask_o[k] = lzb_i & zero_run;
        end
    end

endmodule

// File: rtl/seg_digit_scanner.sv
// Time-multiplexed N-digit driver feeding a single seven-segment decoder.
// Each digit slot starts with BLANK_TICKS cycles of all enables off, followed
// by the ON phase. The whole word (and its suppression mask) is snapshotted at
// the first cycle of every frame so the display never tears.
//   CLK, RST   : clock, asynchronous active-high reset
//   digits     : NUM_DIGITS nibbles, digit 0 = rightmost
//   lzb        : leading-zero blanking enable
//   number     : nibble of the current slot (combinational from the snapshot)
//   digit_en   : one-hot common enable, polarity set by EN_ACTIVE_LOW
//   seg_blank  : 1 forces decoder segments off
//   frame_tick : one-cycle pulse in the first cycle after the idx wrap
module seg_digit_scanner
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned TICKS_PER_DIGIT = 3000,
    parameter int unsigned BLANK_TICKS     = 120,
    parameter bit          EN_ACTIVE_LOW   = 1'b0
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] digits,
    input  logic                           lzb,
    output logic [NIBBLE_W-1:0]            number,
    output logic [NUM_DIGITS-1:0]          digit_en,
    output logic                           seg_blank,
    output logic                           frame_tick
);

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W = $clog2(TICKS_PER_DIGIT);

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
    localparam logic             EN_ON_LVL  = en_on(EN_ACTIVE_LOW);
    localparam logic             EN_OFF_LVL = en_off(EN_ACTIVE_LOW);

    phase_e                        phase_q, phase_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [NIBBLE_W*NUM_DIGITS-1:0] snap_q, snap_d;
    logic [NUM_DIGITS-1:0]         supp_q, supp_d;
    logic [NUM_DIGITS-1:0]         digit_en_q, digit_en_d;
    logic                          seg_blank_q, seg_blank_d;
    logic                          frame_tick_q, frame_tick_d;
    logic [NUM_DIGITS-1:0]         lzb_mask;

    seg_lzb_mask #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lzb_mask (
        .digits_i (digits),
        .lzb_i    (lzb),
        .mask_o   (lzb_mask)
    );

    always_comb begin
        phase_d      = phase_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q + 1'b1;
        snap_d       = snap_q;
        supp_d       = supp_q;
        frame_tick_d = 1'b0;

        if (phase_q == BLANK && idx_q == '0 && cnt_q == '0) begin
            snap_d = digits;
            supp_d = lzb_mask;
        end

        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = BLANK;
            if (idx_q == IDX_LAST) begin
                idx_d        = '0;
                frame_tick_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else if (cnt_q == BLANK_LAST) begin
            phase_d = ON;
        end

        // Outputs are decoded from next state so the registered copies line up
        // exactly with the slot boundaries of the state they describe.
        seg_blank_d = (phase_d == BLANK) || supp_d[idx_d];
        for (int k = 0; k < NUM_DIGITS; k++) begin
            digit_en_d[k] = (phase_d == ON && idx_d == IDX_W'(k) && !supp_d[k]) ?
                            EN_ON_LVL : EN_OFF_LVL;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            phase_q      <= BLANK;
            idx_q        <= '0;
            cnt_q        <= '0;
            snap_q       <= '0;
            supp_q       <= '0;
            digit_en_q   <= {NUM_DIGITS{EN_OFF_LVL}};
            seg_blank_q  <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            snap_q       <= snap_d;
            supp_q       <= supp_d;
            digit_en_q   <= digit_en_d;
            seg_blank_q  <= seg_blank_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign number     = snap_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign digit_en   = digit_en_q;
    assign seg_blank  = seg_blank_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Directed bench for seg_digit_scanner with NUM_DIGITS=4, TICKS_PER_DIGIT=8,
// BLANK_TICKS=2. Two instances share stimulus: one active-high, one active-low.
// Cycle 0 is the cycle that begins when RST is released; frame f spans
// cycles 32f..32f+31.
module tb_seg_digit_scanner;

    logic        CLK;
    logic        RST;
    logic [15:0] digits;
    logic        lzb;
    logic [3:0]  number, number_al;
    logic [3:0]  digit_en, digit_en_al;
    logic        seg_blank, seg_blank_al;
    logic        frame_tick, frame_tick_al;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ticks  = 0;

    seg_digit_scanner #(
        .NUM_DIGITS      (4),
        .TICKS_PER_DIGIT (8),
        .BLANK_TICKS     (2),
        .EN_ACTIVE_LOW   (1'b0)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .digits     (digits),
        .lzb        (lzb),
        .number     (number),
        .digit_en   (digit_en),
        .seg_blank  (seg_blank),
        .frame_tick (frame_tick)
    );

    seg_digit_scanner #(
        .NUM_DIGITS      (4),
        .TICKS_PER_DIGIT (8),
        .BLANK_TICKS     (2),
        .EN_ACTIVE_LOW   (1'b1)
    ) dut_al (
        .CLK        (CLK),
        .RST        (RST),
        .digits     (digits),
        .lzb        (lzb),
        .number     (number_al),
        .digit_en   (digit_en_al),
        .seg_blank  (seg_blank_al),
        .frame_tick (frame_tick_al)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare both instances against one expected slot state.
    task automatic chk_out(input string tag, input logic [3:0] en, input logic [3:0] num,
                           input logic blank, input logic tick);
        logic [3:0] en_al;
        en_al = ~en;
        chk({tag, "_en"},       digit_en,      en);
        chk({tag, "_num"},      number,        num);
        chk({tag, "_blank"},    seg_blank,     blank);
        chk({tag, "_tick"},     frame_tick,    tick);
        chk({tag, "_en_al"},    digit_en_al,   en_al);
        chk({tag, "_num_al"},   number_al,     num);
        chk({tag, "_blank_al"}, seg_blank_al,  blank);
        chk({tag, "_tick_al"},  frame_tick_al, tick);
    endtask

    // Advance to the negedge inside cycle c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(negedge CLK);
            cyc++;
        end
    endtask

    initial begin
        RST    = 1'b1;
        digits = 16'h1234;
        lzb    = 1'b0;
        repeat (3) @(negedge CLK);
        chk_out("reset", 4'b0000, 4'h0, 1'b1, 1'b0);

        // Scenario 1: plain scan of 1234, no suppression.
        RST = 1'b0;
        cyc = 0;
        chk_out("c0",  4'b0000, 4'h0, 1'b1, 1'b0);
        goto(1);  chk_out("c1",  4'b0000, 4'h4, 1'b1, 1'b0);
        goto(2);  chk_out("c2",  4'b0001, 4'h4, 1'b0, 1'b0);
        goto(7);  chk_out("c7",  4'b0001, 4'h4, 1'b0, 1'b0);
        goto(8);  chk_out("c8",  4'b0000, 4'h3, 1'b1, 1'b0);
        goto(10); chk_out("c10", 4'b0010, 4'h3, 1'b0, 1'b0);
        goto(18); chk_out("c18", 4'b0100, 4'h2, 1'b0, 1'b0);
        goto(26); chk_out("c26", 4'b1000, 4'h1, 1'b0, 1'b0);
        goto(31); chk_out("c31", 4'b1000, 4'h1, 1'b0, 1'b0);
        goto(32); chk_out("c32", 4'b0000, 4'h4, 1'b1, 1'b1);
        goto(33); chk_out("c33", 4'b0000, 4'h4, 1'b1, 1'b0);

        // One tick per 32 cycles: cycles 34..97 hold ticks at 64 and 96.
        for (int c = 34; c <= 97; c++) begin
            goto(c);
            if (frame_tick) ticks++;
        end
        chk("tick_count", ticks, 2);

        // Scenario 4: word changes during digit-2 slot of frame 3.
        goto(114);
        digits = 16'h9876;
        chk_out("c114", 4'b0100, 4'h2, 1'b0, 1'b0);
        goto(122); chk_out("c122", 4'b1000, 4'h1, 1'b0, 1'b0);
        goto(130); chk_out("c130", 4'b0001, 4'h6, 1'b0, 1'b0);
        goto(138); chk_out("c138", 4'b0010, 4'h7, 1'b0, 1'b0);
        goto(146); chk_out("c146", 4'b0100, 4'h8, 1'b0, 1'b0);
        goto(154); chk_out("c154", 4'b1000, 4'h9, 1'b0, 1'b0);

        // Scenario 2: 0050 with blanking, visible in frame 5.
        goto(156);
        digits = 16'h0050;
        lzb    = 1'b1;
        goto(162); chk_out("c162", 4'b0001, 4'h0, 1'b0, 1'b0);
        goto(170); chk_out("c170", 4'b0010, 4'h5, 1'b0, 1'b0);
        goto(178); chk_out("c178", 4'b0000, 4'h0, 1'b1, 1'b0);
        goto(186); chk_out("c186", 4'b0000, 4'h0, 1'b1, 1'b0);
        goto(191); chk_out("c191", 4'b0000, 4'h0, 1'b1, 1'b0);

        // Scenario 3: all zero, only digit 0 lit in frame 6.
        goto(188);
        digits = 16'h0000;
        goto(194); chk_out("c194", 4'b0001, 4'h0, 1'b0, 1'b0);
        goto(202); chk_out("c202", 4'b0000, 4'h0, 1'b1, 1'b0);
        goto(210); chk_out("c210", 4'b0000, 4'h0, 1'b1, 1'b0);
        goto(218); chk_out("c218", 4'b0000, 4'h0, 1'b1, 1'b0);

        // Embedded zero below a non-zero digit is kept; hex passes through.
        goto(220);
        digits = 16'h0A05;
        goto(226); chk_out("c226", 4'b0001, 4'h5, 1'b0, 1'b0);
        goto(234); chk_out("c234", 4'b0010, 4'h0, 1'b0, 1'b0);
        goto(242); chk_out("c242", 4'b0100, 4'hA, 1'b0, 1'b0);
        goto(250); chk_out("c250", 4'b0000, 4'h0, 1'b1, 1'b0);

        // Scenario 5: asynchronous reset in ON phase of digit 1 (frame 8).
        goto(252);
        digits = 16'h1234;
        lzb    = 1'b0;
        goto(268); chk_out("c268", 4'b0010, 4'h3, 1'b0, 1'b0);
        #2 RST = 1'b1;
        #1 chk_out("async_rst", 4'b0000, 4'h0, 1'b1, 1'b0);
        @(negedge CLK);
        digits = 16'hABCD;
        @(negedge CLK);
        RST = 1'b0;
        cyc = 0;
        goto(1);  chk_out("r1",  4'b0000, 4'hD, 1'b1, 1'b0);
        goto(2);  chk_out("r2",  4'b0001, 4'hD, 1'b0, 1'b0);
        goto(10); chk_out("r10", 4'b0010, 4'hC, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
